neuron_mac_seq: RTL and testbench
=================================

// Module: neuron_mac_seq
// PURPOSE
// - Parametrised sequential neuron datapath: accumulates N_INPUTS sign-magnitude input*weight products,
//   LANES products per accepted beat, then adds a scaled bias, applies ReLU, rescales and saturates.
// - Sits between the layer controller (start / out handshake) and the input/weight memories (in handshake).
// - Outputs one sign-magnitude neuron activation per run, held until consumed.
// PARAMETERS
// - DATA_W      8   width of input, weight, bias, result; bit DATA_W-1 = sign, rest = magnitude
// - N_INPUTS    16  products per neuron; must be a multiple of LANES
// - LANES       1   products accumulated per accepted beat (1..N_INPUTS)
// - FRAC_SHIFT  7   right shift applied to ReLU'd accumulator before saturation
// - ACC_W       2*(DATA_W-1)+$clog2(N_INPUTS+2)+1  two's-complement accumulator width (derived, overflow-free)
// PORTS
// - clk        in   1               rising-edge clock
// - rst        in   1               asynchronous, active-low reset (0 = reset)
// - start      in   1               pulse: begin run, capture bias (honoured only in IDLE)
// - bias       in   DATA_W          sign-magnitude bias, sampled on accepted start
// - in_valid   in   1               in_data/in_weight beat valid
// - in_ready   out  1               block accepts a beat (high only in ACCUM)
// - in_data    in   LANES*DATA_W    lane i at [i*DATA_W +: DATA_W], sign-magnitude
// - in_weight  in   LANES*DATA_W    lane i at [i*DATA_W +: DATA_W], sign-magnitude
// - out_valid  out  1               result valid; held until out_ready
// - out_ready  in   1               consumer accepts result
// - result     out  DATA_W          sign-magnitude activation
// - busy       out  1               high in every state except IDLE
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, acc=0, beat counter=0; in_ready=0, out_valid=0, result=0, busy=0.
// - FSM: IDLE -(start)-> ACCUM -(last beat accepted)-> BIAS -> OUT -(out_valid&&out_ready)-> IDLE.
// - IDLE: on start, acc<=0, counter<=0, bias register<=bias. start in any other state ignored.
// - ACCUM: in_ready=1; beat accepted when in_valid&&in_ready. Per lane: mag=|d|*|w| (DATA_W-1 x DATA_W-1
//   unsigned), sign=d[MSB]^w[MSB]; signed term = sign ? -mag : mag; lane terms summed and added to acc
//   in the same cycle. Magnitude 0 with sign 1 (negative zero) contributes 0.
// - After N_INPUTS/LANES accepted beats -> BIAS; in_ready drops the cycle after the last accept.
// - BIAS (1 cycle): acc <= acc + signed(|bias| * (2^(DATA_W-1)-1)) (bias scaled to product format).
// - OUT entry: r = (acc<=0) ? 0 : acc>>>FRAC_SHIFT; result = {1'b0, min(r, 2^(DATA_W-1)-1)}; out_valid=1.
// - Latency: out_valid asserts 2 cycles after the last beat is accepted.
// - result and out_valid stable while out_ready=0; on handshake out_valid=0 next cycle, result holds value.
// - out_ready ignored when out_valid=0; in_valid ignored outside ACCUM.
// - Reset mid-run: run abandoned, all state to reset values; no partial result emitted.
// CONFIGURATION
// - Macro LEAKY_RELU_EN.
// - Undefined: ReLU as above, negative accumulator -> result 0.
// - Defined: negative accumulator -> result = {1'b1, min(|acc|>>(FRAC_SHIFT+3), 2^(DATA_W-1)-1)};
//   positive path unchanged; acc=0 -> 0 (never negative zero).
// TESTING (DATA_W=8, N_INPUTS=4, LANES=1, FRAC_SHIFT=7 unless stated)
// - Inputs 1,2,3,4, weights 8'h7F, bias 0 -> acc=1270, result 8'h09, out_valid 2 cycles after 4th beat.
// - Inputs 8'h0A x4, weights 8'hFF, bias 0 -> acc=-5080, result 8'h00; with LEAKY_RELU_EN result 8'h84.
// - Inputs 8'h7F x4, weights 8'h7F, bias 8'h7F -> acc=80645, saturated result 8'h7F.
// - Negative zero: in_data 8'h80 x4, any weights, bias 8'h02 -> acc=254, result 8'h01.
// - Backpressure: out_ready low 5 cycles -> out_valid/result stable, start pulses ignored, in_ready=0;
//   in_valid gaps during ACCUM stall counting without error.
// - rst=0 after 2 beats -> outputs/state at reset values immediately; next full run of test 1 gives 8'h09.
// - LANES=2: two beats {1,2},{3,4}, weights 8'h7F -> result 8'h09.

Source files
------------

// File: rtl/neuron_mac_if.sv
// Handshake bundle between the layer controller, the input/weight memories and one neuron datapath.
// No latency of its own; it only groups wires.
// Backpressure is carried by in_valid/in_ready and out_valid/out_ready.
//
// Ports: start/bias come from the controller. in_valid/in_data/in_weight/in_ready form the beat
// stream from memory. out_valid/out_ready/result form the result handshake. busy is status.
// The master modport is the driving side. The slave modport is the neuron.
interface neuron_mac_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1
);
  logic                      start;
  logic [DATA_W-1:0]         bias;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [LANES*DATA_W-1:0]   in_weight;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         result;
  logic                      busy;

  modport master (
    output start, bias, in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  start, bias, in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: sums N_INPUTS sign-magnitude products, adds a scaled bias, applies ReLU, then rescales and saturates.
// Latency: out_valid rises 2 cycles after the last beat is accepted (one BIAS cycle, then OUT).
// Backpressure: in_ready is high only while accumulating. The result is held until out_ready; start is ignored while busy.
//
// Ports: clk, rst (async, active-low), io (neuron_mac_if.slave: start/bias, beat stream, result handshake, busy).
// Optional macro LEAKY_RELU_EN: negative sums give a small negative result instead of zero.
module neuron_mac_seq #(
  parameter int DATA_W     = 8,
  parameter int N_INPUTS   = 16,
  parameter int LANES      = 1,
  parameter int FRAC_SHIFT = 7
) (
  input  logic          clk,
  input  logic          rst,
  neuron_mac_if.slave   io
);
  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int ACC_W  = 2 * (DATA_W - 1) + $clog2(N_INPUTS + 2) + 1;
  localparam int BEATS  = N_INPUTS / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [MAG_W-1:0] MAX_MAG = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        bias_q, bias_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  bias_term;

  function automatic logic [MAG_W-1:0] sat(input logic [ACC_W-1:0] v);
    return (v > ACC_W'(MAX_MAG)) ? MAX_MAG : v[MAG_W-1:0];
  endfunction

  // Rescale the final sum into a sign-magnitude activation. A zero magnitude is always emitted as +0.
  function automatic logic [DATA_W-1:0] activate(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-1:0]  sh;
    logic [DATA_W-1:0] r;
    r  = '0;
    sh = '0;
    if (a > 0) begin
      sh = a >>> FRAC_SHIFT;
      r  = {1'b0, sat(sh)};
    end
`ifdef LEAKY_RELU_EN
    else if (a < 0) begin
      sh = (-a) >> (FRAC_SHIFT + 3);
      if (sh != '0) r = {1'b1, sat(sh)};
    end
`endif
    return r;
  endfunction

  // Signed sum of all lane products in the current beat. A product with zero magnitude is
  // negated to 0, so negative-zero operands contribute nothing.
  always_comb begin
    logic [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0] term;
    logic                    neg;
    lane_sum = '0;
    prod     = '0;
    term     = '0;
    neg      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      prod = PROD_W'(io.in_data[i*DATA_W +: MAG_W]) * PROD_W'(io.in_weight[i*DATA_W +: MAG_W]);
      neg  = io.in_data[i*DATA_W + MAG_W] ^ io.in_weight[i*DATA_W + MAG_W];
      term = $signed({{(ACC_W-PROD_W){1'b0}}, prod});
      if (neg) term = -term;
      lane_sum = lane_sum + term;
    end
  end

  // Bias is scaled by the full-scale weight so that it has the same format as a product.
  always_comb begin
    logic [PROD_W-1:0] bprod;
    bprod     = PROD_W'(bias_q[MAG_W-1:0]) * PROD_W'(MAX_MAG);
    bias_term = $signed({{(ACC_W-PROD_W){1'b0}}, bprod});
    if (bias_q[MAG_W]) bias_term = -bias_term;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          bias_d  = io.bias;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (io.in_valid) begin
          acc_d = acc_q + lane_sum;
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_BIAS;
          else                            cnt_d   = cnt_q + 1'b1;
        end
      end
      S_BIAS: begin
        // The result is registered together with the final sum, so OUT presents it with no extra cycle.
        acc_d       = acc_q + bias_term;
        result_d    = activate(acc_d);
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bias_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = (state_q == S_ACCUM);
  assign io.busy      = (state_q != S_IDLE);
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef LEAKY_RELU_EN
  localparam logic [7:0] NEG_EXP = 8'h84;
`else
  localparam logic [7:0] NEG_EXP = 8'h00;
`endif

  neuron_mac_if #(.DATA_W(8), .LANES(1)) b1 ();
  neuron_mac_if #(.DATA_W(8), .LANES(2)) b2 ();

  neuron_mac_seq #(.DATA_W(8), .N_INPUTS(4), .LANES(1), .FRAC_SHIFT(7)) dut1 (
    .clk (clk),
    .rst (rst),
    .io  (b1.slave)
  );

  neuron_mac_seq #(.DATA_W(8), .N_INPUTS(4), .LANES(2), .FRAC_SHIFT(7)) dut2 (
    .clk (clk),
    .rst (rst),
    .io  (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; samples and drives happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic [7:0] bias_v);
    b1.start = 1'b1;
    b1.bias  = bias_v;
    step();
    b1.start = 1'b0;
  endtask

  // Presents n beats to dut1 from packed byte vectors (beat i at [i*8 +: 8]). A gap inserts idle cycles between beats.
  task automatic feed1(input logic [31:0] dv, input logic [31:0] wv, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i > 0) begin
        b1.in_valid = 1'b0;
        repeat (gap) step();
      end
      b1.in_valid  = 1'b1;
      b1.in_data   = dv[i*8 +: 8];
      b1.in_weight = wv[i*8 +: 8];
      step();
    end
    b1.in_valid = 1'b0;
  endtask

  task automatic wait_out1(output int cyc);
    cyc = 0;
    while (b1.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic consume1();
    b1.out_ready = 1'b1;
    step();
    b1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++; if (b1.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", b1.in_ready); end
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b1.out_valid); end
    checks++; if (b1.result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", b1.result); end
    checks++; if (b1.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b1.busy); end
    rst = 1'b1;
    step();
  endtask

  // Inputs 1,2,3,4 with weight 127 sum to 1270; 1270>>7 = 9.
  task automatic test_basic();
    start1(8'h00);
    checks++; if (b1.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", b1.busy); end
    checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", b1.in_ready); end
    feed1(32'h04030201, 32'h7F7F7F7F, 4, 0);
    // The cycle after the last accept is the bias cycle, and OUT follows it.
    checks++; if (b1.in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_drop got=%b exp=0", b1.in_ready); end
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", b1.out_valid); end
    step();
    checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", b1.out_valid); end
    checks++; if (b1.result !== 8'h09) begin failures++; $display("FAIL basic_result got=%h exp=09", b1.result); end
    consume1();
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_clear got=%b exp=0", b1.out_valid); end
    checks++; if (b1.result !== 8'h09) begin failures++; $display("FAIL basic_result_hold got=%h exp=09", b1.result); end
    checks++; if (b1.busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", b1.busy); end
  endtask

  // 10 * -127 * 4 = -5080. ReLU gives 0; the leaky path gives -(5080>>10) = -4.
  task automatic test_negative();
    int cyc;
    start1(8'h00);
    feed1(32'h0A0A0A0A, 32'hFFFFFFFF, 4, 0);
    wait_out1(cyc);
    checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL neg_timeout got=%b exp=1", b1.out_valid); end
    checks++; if (b1.result !== NEG_EXP) begin failures++; $display("FAIL neg_result got=%h exp=%h", b1.result, NEG_EXP); end
    consume1();
  endtask

  // 4*127*127 + 127*127 = 80645; 80645>>7 = 630 saturates to 127.
  task automatic test_saturate();
    int cyc;
    start1(8'h7F);
    feed1(32'h7F7F7F7F, 32'h7F7F7F7F, 4, 0);
    wait_out1(cyc);
    checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL sat_timeout got=%b exp=1", b1.out_valid); end
    checks++; if (b1.result !== 8'h7F) begin failures++; $display("FAIL sat_result got=%h exp=7F", b1.result); end
    consume1();
  endtask

  // Negative-zero inputs contribute 0. Bias 2*127 = 254, and 254>>7 = 1.
  task automatic test_neg_zero();
    int cyc;
    start1(8'h02);
    feed1(32'h80808080, 32'hD5FF3381, 4, 0);
    wait_out1(cyc);
    checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL negzero_timeout got=%b exp=1", b1.out_valid); end
    checks++; if (b1.result !== 8'h01) begin failures++; $display("FAIL negzero_result got=%h exp=01", b1.result); end
    consume1();
  endtask

  task automatic test_backpressure();
    int cyc;
    // Beats offered while idle must not be accepted.
    b1.in_valid  = 1'b1;
    b1.in_data   = 8'h7F;
    b1.in_weight = 8'h7F;
    step();
    step();
    b1.in_valid = 1'b0;
    start1(8'h00);
    feed1(32'h00030201, 32'h007F7F7F, 3, 2);
    b1.in_valid = 1'b0;
    repeat (3) step();
    checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL bp_gap_in_ready got=%b exp=1", b1.in_ready); end
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL bp_gap_valid got=%b exp=0", b1.out_valid); end
    feed1(32'h00000004, 32'h0000007F, 1, 0);
    wait_out1(cyc);
    checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", b1.out_valid); end
    for (int k = 0; k < 5; k++) begin
      b1.start = 1'b1;
      b1.bias  = 8'h7F;
      step();
      checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", k, b1.out_valid); end
      checks++; if (b1.result !== 8'h09) begin failures++; $display("FAIL bp_hold_result[%0d] got=%h exp=09", k, b1.result); end
      checks++; if (b1.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", k, b1.in_ready); end
    end
    b1.start = 1'b0;
    consume1();
    checks++; if (b1.busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", b1.busy); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    start1(8'h00);
    feed1(32'h00000201, 32'h00007F7F, 2, 0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (b1.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", b1.busy); end
    checks++; if (b1.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", b1.in_ready); end
    checks++; if (b1.result !== 8'h00) begin failures++; $display("FAIL midrst_result got=%h exp=00", b1.result); end
    step();
    step();
    rst = 1'b1;
    step();
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_partial got=%b exp=0", b1.out_valid); end
    start1(8'h00);
    feed1(32'h04030201, 32'h7F7F7F7F, 4, 0);
    wait_out1(cyc);
    checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_rerun_timeout got=%b exp=1", b1.out_valid); end
    checks++; if (b1.result !== 8'h09) begin failures++; $display("FAIL midrst_rerun_result got=%h exp=09", b1.result); end
    consume1();
  endtask

  // Two lanes: beats {1,2} and {3,4} with weight 127 still sum to 1270.
  task automatic test_lanes2();
    b2.start = 1'b1;
    b2.bias  = 8'h00;
    step();
    b2.start     = 1'b0;
    b2.in_valid  = 1'b1;
    b2.in_weight = 16'h7F7F;
    b2.in_data   = 16'h0201;
    step();
    b2.in_data   = 16'h0403;
    step();
    b2.in_valid  = 1'b0;
    checks++; if (b2.in_ready !== 1'b0) begin failures++; $display("FAIL lanes2_in_ready got=%b exp=0", b2.in_ready); end
    step();
    checks++; if (b2.out_valid !== 1'b1) begin failures++; $display("FAIL lanes2_latency got=%b exp=1", b2.out_valid); end
    checks++; if (b2.result !== 8'h09) begin failures++; $display("FAIL lanes2_result got=%h exp=09", b2.result); end
    b2.out_ready = 1'b1;
    step();
    b2.out_ready = 1'b0;
    checks++; if (b2.out_valid !== 1'b0) begin failures++; $display("FAIL lanes2_valid_clear got=%b exp=0", b2.out_valid); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    b1.start     = 1'b0;
    b1.bias      = '0;
    b1.in_valid  = 1'b0;
    b1.in_data   = '0;
    b1.in_weight = '0;
    b1.out_ready = 1'b0;
    b2.start     = 1'b0;
    b2.bias      = '0;
    b2.in_valid  = 1'b0;
    b2.in_data   = '0;
    b2.in_weight = '0;
    b2.out_ready = 1'b0;
    #3;
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_neg_zero();
    test_backpressure();
    test_reset_midrun();
    test_lanes2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
